// File: rtl/drive_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module  : drive_buf_pkg
// Brief   : Shared types and defaults for the drive_buf elastic buffer.
// Revision: 1.0 - initial release
// ============================================================================
package drive_buf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drive_buf_state_e;

endpackage : drive_buf_pkg
`default_nettype wire

// File: rtl/drive_buf_if.sv
`default_nettype none
// ============================================================================
// Module  : drive_buf_if
// Brief   : Producer/consumer handshake bundle plus status for drive_buf.
// Revision: 1.0 - initial release
// ============================================================================
interface drive_buf_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic [LVL_W-1:0]  level;
    logic              done;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, level, done
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, level, done
    );
endinterface : drive_buf_if
`default_nettype wire

// File: rtl/drive_buf_ram.sv
`default_nettype none
// ============================================================================
// Module  : drive_buf_ram
// Brief   : DEPTH x WIDTH storage, one synchronous write port, async read.
// Revision: 1.0 - initial release
// ============================================================================
module drive_buf_ram #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk_i,
    input  wire logic                     we_i,
    input  wire logic [$clog2(DEPTH)-1:0] waddr_i,
    input  wire logic [WIDTH-1:0]         wdata_i,
    input  wire logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic      [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule : drive_buf_ram
`default_nettype wire

// File: rtl/drive_buf.sv
`default_nettype none
// ============================================================================
// Module  : drive_buf
// Brief   : First-word-fall-through elastic buffer with end-of-stream tracking.
//           Optional DRIVE_BUF_STATS_EN adds push/pop counters and high-water mark.
// Revision: 1.0 - initial release
// ============================================================================
module drive_buf
    import drive_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  wire logic   v_clk,
    input  wire logic   v_rst,
    drive_buf_if.slave  bus
`ifdef DRIVE_BUF_STATS_EN
    ,
    output logic [31:0]                  push_cnt,
    output logic [31:0]                  pop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   hwm
`endif
);
    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    drive_buf_state_e state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             w_full, w_empty, w_push, w_pop;
    logic [PTR_W-1:0] w_level;
    logic [DATA_W:0]  w_rdata;

    // MSB differs with equal address bits only after a full lap of the writer
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_level = wr_ptr_q - rd_ptr_q;

    assign w_push = bus.in_valid  & bus.in_ready;
    assign w_pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge v_clk) begin
        if (v_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    drive_buf_ram #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i   (v_clk),
        .we_i    (w_push),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({bus.in_last, bus.in_data}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (w_rdata)
    );

    // FSM: state register
    always_ff @(posedge v_clk) begin
        if (v_rst) state_q <= RUN;
        else       state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (w_push && bus.in_last)  state_d = DRAIN;
            DRAIN:   if (w_pop && bus.out_last)  state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    // FSM: outputs, all from registered state so out_ready never reaches in_ready
    always_comb begin
        bus.in_ready  = (state_q == RUN) && !w_full;
        bus.out_valid = !w_empty && (state_q != DONE);
        bus.done      = (state_q == DONE);
    end

    assign bus.out_data = w_rdata[DATA_W-1:0];
    assign bus.out_last = w_rdata[DATA_W] & bus.out_valid;
    assign bus.level    = LVL_W'(w_level);

`ifdef DRIVE_BUF_STATS_EN
    logic [31:0]      push_cnt_q, pop_cnt_q;
    logic [LVL_W-1:0] hwm_q, hwm_d;
    logic [PTR_W-1:0] w_level_nxt;

    assign w_level_nxt = wr_ptr_d - rd_ptr_d;

    always_comb begin
        hwm_d = hwm_q;
        if (LVL_W'(w_level_nxt) > hwm_q) hwm_d = LVL_W'(w_level_nxt);
    end

    always_ff @(posedge v_clk) begin
        if (v_rst) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            hwm_q      <= '0;
        end else begin
            if (w_push) push_cnt_q <= push_cnt_q + 32'd1;
            if (w_pop)  pop_cnt_q  <= pop_cnt_q + 32'd1;
            hwm_q <= hwm_d;
        end
    end

    assign push_cnt = push_cnt_q;
    assign pop_cnt  = pop_cnt_q;
    assign hwm      = hwm_q;
`endif
endmodule : drive_buf
`default_nettype wire

// File: tb/tb_drive_buf.sv
`default_nettype none
// ============================================================================
// Module  : tb_drive_buf
// Brief   : Scoreboard bench for drive_buf; stats checks under DRIVE_BUF_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tb_drive_buf;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [DATA_W:0] exp_q[$];

    drive_buf_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

`ifdef DRIVE_BUF_STATS_EN
    logic [31:0] push_cnt, pop_cnt;
    logic [2:0]  hwm;
`endif

    drive_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .v_clk (clk),
        .v_rst (rst),
        .bus   (bus)
`ifdef DRIVE_BUF_STATS_EN
        ,
        .push_cnt (push_cnt),
        .pop_cnt  (pop_cnt),
        .hwm      (hwm)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; accepted words go into the scoreboard
    task automatic drive(input logic v, input logic [31:0] d, input logic l,
                         input logic ordy, input logic exp_acc);
        @(posedge clk);
        #1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = ordy;
        @(negedge clk);
        if (v) begin
            check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_acc});
            if (exp_acc) exp_q.push_back({l, d});
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got 0x%0h expected no output", bus.out_data);
            end else begin
                logic [DATA_W:0] e;
                e = exp_q.pop_front();
                check("pop_data", bus.out_data, e[DATA_W-1:0]);
                check("pop_last", {31'd0, bus.out_last}, {31'd0, e[DATA_W]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_level", {29'd0, bus.level}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Fill to full; fifth word refused
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h10 + i, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
        check("full_level", {29'd0, bus.level}, 32'd4);
        check("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
`ifdef DRIVE_BUF_STATS_EN
        check("stat_push_cnt", push_cnt, 32'd4);
        check("stat_pop_cnt", pop_cnt, 32'd0);
        check("stat_hwm", {29'd0, hwm}, 32'd4);
`endif

        // Full with pop: pop wins, push refused
        drive(1'b1, 32'h15, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("fullpop_level", {29'd0, bus.level}, 32'd3);

        repeat (3) drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("drained_level", {29'd0, bus.level}, 32'd0);
        check("drained_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Streaming
        for (int i = 0; i < 20; i++) drive(1'b1, i, 1'b0, 1'b1, 1'b1);
        check("stream_level", {29'd0, bus.level}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("stream_end_level", {29'd0, bus.level}, 32'd0);

        // End of stream
        drive(1'b1, 32'h5, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h6, 1'b0, 1'b0, 1'b0);
        check("drain_done", {31'd0, bus.done}, 32'd0);
        drive(1'b1, 32'h7, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("done_set", {31'd0, bus.done}, 32'd1);
        check("done_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("done_level", {29'd0, bus.level}, 32'd0);
        drive(1'b1, 32'h8, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("done_sticky", {31'd0, bus.done}, 32'd1);

        // Reset out of DONE, fill three, reset mid-run
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst2_done", {31'd0, bus.done}, 32'd0);
        check("rst2_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h20 + i, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("mid_level", {29'd0, bus.level}, 32'd3);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_level", {29'd0, bus.level}, 32'd0);
        check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef DRIVE_BUF_STATS_EN
        check("stat_rst_push_cnt", push_cnt, 32'd0);
        check("stat_rst_hwm", {29'd0, hwm}, 32'd0);
`endif
        drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("head_valid", {31'd0, bus.out_valid}, 32'd1);
        check("head_data", bus.out_data, 32'hA);
        check("head_level", {29'd0, bus.level}, 32'd1);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("final_level", {29'd0, bus.level}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_drive_buf
`default_nettype wire
